// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - run-control sequencer gating commits of the single-cycle MIPS core
module mips_run_ctrl #(
    parameter int          CNT_W        = 32,
    parameter logic [31:0] SYSCALL_WORD = 32'h0000000c
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } state_e;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_STOP = 2'd1;
    localparam logic [1:0] C_SYS  = 2'd2;
    localparam logic [1:0] C_BP   = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [1:0]        cause_q, cause_d;
    logic              bp_skip_q, bp_skip_d;
    logic [CNT_W-1:0]  cycle_q, retired_q;

    logic              is_sys;
    logic              halt_hit;
    logic              active;
    logic [1:0]        hit_cause;

    always_comb begin
        is_sys    = (instr == SYSCALL_WORD);
        halt_hit  = is_sys || (bp_en && (pc == bp_addr) && !bp_skip_q);
        active    = (state_q == S_RUN) || (state_q == S_STEP);
        cpu_en    = active && !halt_hit;
        // a syscall in the same cycle as a breakpoint must win so the halt stays terminal
        hit_cause = is_sys ? C_SYS : C_BP;
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        bp_skip_d = bp_skip_q;
        if (cpu_en) begin
            bp_skip_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (step) begin
                    state_d = S_STEP;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_hit) begin
                    state_d = S_HALT;
                    cause_d = hit_cause;
                end else if (stop) begin
                    state_d = S_HALT;
                    cause_d = C_STOP;
                end
            end
            S_STEP: begin
                if (halt_hit) begin
                    state_d = S_HALT;
                    cause_d = hit_cause;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                if ((cause_q != C_SYS) && (step || start)) begin
                    state_d = step ? S_STEP : S_RUN;
                    cause_d = C_NONE;
                    // let the breakpointed instruction retire once on resume
                    if (cause_q == C_BP) begin
                        bp_skip_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cause_q   <= C_NONE;
            bp_skip_q <= 1'b0;
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            bp_skip_q <= bp_skip_d;
            if (active) begin
                cycle_q <= cycle_q + CNT_ONE;
            end
            if (cpu_en) begin
                retired_q <= retired_q + CNT_ONE;
            end
        end
    end

    assign state       = state_q;
    assign halt_cause  = cause_q;
    assign cycle_cnt   = cycle_q;
    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb/tb_mips_run_ctrl.sv - scoreboard bench for mips_run_ctrl
module tb_mips_run_ctrl;

    localparam logic [31:0] ADDI = 32'h20a50001;
    localparam logic [31:0] SYSC = 32'h0000000c;
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_RUN  = 2'd1;
    localparam logic [1:0]  ST_STEP = 2'd2;
    localparam logic [1:0]  ST_HALT = 2'd3;

    logic        clk = 1'b0;
    logic        reset, start, stop, step, bp_en;
    logic [31:0] bp_addr, pc, instr;
    logic        cpu_en, cpu_en4;
    logic [1:0]  state, halt_cause, state4, cause4;
    logic [31:0] cycle_cnt, retired_cnt;
    logic [3:0]  cycle4, retired4;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       en;
        logic [1:0] st;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mips_run_ctrl u_dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr(instr),
        .cpu_en(cpu_en), .state(state), .halt_cause(halt_cause),
        .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
    );

    mips_run_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr(instr),
        .cpu_en(cpu_en4), .state(state4), .halt_cause(cause4),
        .cycle_cnt(cycle4), .retired_cnt(retired4)
    );

    // Drive one cycle's inputs, record the expected same-cycle outputs, compare at the falling edge.
    task automatic cyc(input logic s, input logic sp, input logic sd,
                       input logic [31:0] p, input logic [31:0] ins,
                       input logic e_en, input logic [1:0] e_st, input string tag);
        exp_t e;
        start = s; stop = sp; step = sd; pc = p; instr = ins;
        exp_q.push_back({e_en, e_st});
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (cpu_en !== e.en) begin
            bad++;
            $display("FAIL %s cpu_en got=%0b want=%0b", tag, cpu_en, e.en);
        end
        total++;
        if (state !== e.st) begin
            bad++;
            $display("FAIL %s state got=%0d want=%0d", tag, state, e.st);
        end
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; step = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        bp_en = 1'b0; pc = 32'h3000; instr = ADDI;
        #1;
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
        total++; if (halt_cause !== 2'd0) begin bad++; $display("FAIL rst_cause got=%0d want=0", halt_cause); end
        total++; if (cycle_cnt !== 32'd0) begin bad++; $display("FAIL rst_cycle got=%0d want=0", cycle_cnt); end
        total++; if (retired_cnt !== 32'd0) begin bad++; $display("FAIL rst_retired got=%0d want=0", retired_cnt); end
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL rst_cpu_en got=%0b want=0", cpu_en); end
    endtask

    task automatic test_syscall();
        do_reset();
        bp_en = 1'b0; bp_addr = 32'h0;
        cyc(1, 0, 0, 32'h3000, ADDI, 0, ST_IDLE, "sys_start");
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 32'h3000 + 32'(i * 4), ADDI, 1, ST_RUN, "sys_run");
        end
        cyc(0, 0, 0, 32'h3014, SYSC, 0, ST_RUN, "sys_blocked");
        total++; if (state !== ST_HALT) begin bad++; $display("FAIL sys_state got=%0d want=3", state); end
        total++; if (halt_cause !== 2'd2) begin bad++; $display("FAIL sys_cause got=%0d want=2", halt_cause); end
        total++; if (retired_cnt !== 32'd5) begin bad++; $display("FAIL sys_retired got=%0d want=5", retired_cnt); end
        total++; if (cycle_cnt !== 32'd6) begin bad++; $display("FAIL sys_cycle got=%0d want=6", cycle_cnt); end
        cyc(1, 0, 0, 32'h3014, SYSC, 0, ST_HALT, "sys_sticky_start");
        cyc(0, 0, 1, 32'h3014, SYSC, 0, ST_HALT, "sys_sticky_step");
        total++; if (state !== ST_HALT) begin bad++; $display("FAIL sys_sticky got=%0d want=3", state); end
        total++; if (cycle_cnt !== 32'd6) begin bad++; $display("FAIL sys_cycle_hold got=%0d want=6", cycle_cnt); end
    endtask

    task automatic test_breakpoint();
        do_reset();
        bp_en = 1'b1; bp_addr = 32'h3008;
        cyc(1, 0, 0, 32'h3000, ADDI, 0, ST_IDLE, "bp_start");
        cyc(0, 0, 0, 32'h3000, ADDI, 1, ST_RUN, "bp_run0");
        cyc(0, 0, 0, 32'h3004, ADDI, 1, ST_RUN, "bp_run1");
        cyc(0, 0, 0, 32'h3008, ADDI, 0, ST_RUN, "bp_hit");
        total++; if (halt_cause !== 2'd3) begin bad++; $display("FAIL bp_cause got=%0d want=3", halt_cause); end
        total++; if (retired_cnt !== 32'd2) begin bad++; $display("FAIL bp_retired got=%0d want=2", retired_cnt); end
        cyc(1, 0, 0, 32'h3008, ADDI, 0, ST_HALT, "bp_resume");
        total++; if (halt_cause !== 2'd0) begin bad++; $display("FAIL bp_cause_clr got=%0d want=0", halt_cause); end
        cyc(0, 0, 0, 32'h3008, ADDI, 1, ST_RUN, "bp_skip_commit");
        total++; if (retired_cnt !== 32'd3) begin bad++; $display("FAIL bp_retired3 got=%0d want=3", retired_cnt); end
        cyc(0, 0, 0, 32'h300c, ADDI, 1, ST_RUN, "bp_run2");
        cyc(0, 0, 0, 32'h3010, ADDI, 1, ST_RUN, "bp_run3");
        cyc(0, 0, 0, 32'h3008, ADDI, 0, ST_RUN, "bp_rehit");
        total++; if (state !== ST_HALT) begin bad++; $display("FAIL bp_rehit_state got=%0d want=3", state); end
        total++; if (halt_cause !== 2'd3) begin bad++; $display("FAIL bp_rehit_cause got=%0d want=3", halt_cause); end
        total++; if (retired_cnt !== 32'd5) begin bad++; $display("FAIL bp_retired5 got=%0d want=5", retired_cnt); end
    endtask

    task automatic test_single_step();
        do_reset();
        bp_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 32'h3000 + 32'(i * 4), ADDI, 0, ST_IDLE, "step_req");
            cyc(0, 0, 0, 32'h3000 + 32'(i * 4), ADDI, 1, ST_STEP, "step_commit");
        end
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL step_state got=%0d want=0", state); end
        total++; if (retired_cnt !== 32'd3) begin bad++; $display("FAIL step_retired got=%0d want=3", retired_cnt); end
        total++; if (cycle_cnt !== 32'd3) begin bad++; $display("FAIL step_cycle got=%0d want=3", cycle_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bp_en = 1'b0;
        cyc(1, 0, 0, 32'h3000, ADDI, 0, ST_IDLE, "b2b_start");
        cyc(0, 0, 0, 32'h3000, ADDI, 1, ST_RUN, "b2b_run");
        cyc(0, 1, 1, 32'h3004, ADDI, 1, ST_RUN, "b2b_stop_step");
        total++; if (halt_cause !== 2'd1) begin bad++; $display("FAIL b2b_cause got=%0d want=1", halt_cause); end
        total++; if (retired_cnt !== 32'd2) begin bad++; $display("FAIL b2b_retired got=%0d want=2", retired_cnt); end
        cyc(1, 0, 1, 32'h3008, ADDI, 0, ST_HALT, "b2b_start_step");
        cyc(1, 0, 0, 32'h3008, ADDI, 1, ST_STEP, "b2b_step_commit");
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL b2b_state got=%0d want=0", state); end
        total++; if (cycle_cnt !== 32'd3) begin bad++; $display("FAIL b2b_cycle got=%0d want=3", cycle_cnt); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bp_en = 1'b1; bp_addr = 32'h3008;
        cyc(1, 0, 0, 32'h3000, ADDI, 0, ST_IDLE, "mr_start");
        cyc(0, 0, 0, 32'h3000, ADDI, 1, ST_RUN, "mr_run0");
        cyc(0, 0, 0, 32'h3004, ADDI, 1, ST_RUN, "mr_run1");
        cyc(0, 0, 0, 32'h3008, ADDI, 0, ST_RUN, "mr_hit");
        cyc(1, 0, 0, 32'h3008, ADDI, 0, ST_HALT, "mr_resume");
        reset = 1'b1;
        cyc(0, 0, 0, 32'h3008, ADDI, 1, ST_RUN, "mr_reset_cycle");
        reset = 1'b0;
        total++; if (cycle_cnt !== 32'd0) begin bad++; $display("FAIL mr_cycle got=%0d want=0", cycle_cnt); end
        total++; if (retired_cnt !== 32'd0) begin bad++; $display("FAIL mr_retired got=%0d want=0", retired_cnt); end
        total++; if (halt_cause !== 2'd0) begin bad++; $display("FAIL mr_cause got=%0d want=0", halt_cause); end
        cyc(1, 0, 0, 32'h3008, ADDI, 0, ST_IDLE, "mr_idle");
        cyc(0, 0, 0, 32'h3008, ADDI, 0, ST_RUN, "mr_bp_rearmed");
        total++; if (halt_cause !== 2'd3) begin bad++; $display("FAIL mr_bp_cause got=%0d want=3", halt_cause); end
    endtask

    task automatic test_wrap();
        do_reset();
        bp_en = 1'b0;
        cyc(1, 0, 0, 32'h3000, ADDI, 0, ST_IDLE, "wrap_start");
        for (int i = 0; i < 17; i++) begin
            cyc(0, 0, 0, 32'h3000 + 32'(i * 4), ADDI, 1, ST_RUN, "wrap_run");
        end
        total++; if (retired4 !== 4'd1) begin bad++; $display("FAIL wrap_retired4 got=%0d want=1", retired4); end
        total++; if (cycle4 !== 4'd1) begin bad++; $display("FAIL wrap_cycle4 got=%0d want=1", cycle4); end
        total++; if (state4 !== ST_RUN) begin bad++; $display("FAIL wrap_state4 got=%0d want=1", state4); end
        total++; if (cause4 !== 2'd0) begin bad++; $display("FAIL wrap_cause4 got=%0d want=0", cause4); end
        total++; if (retired_cnt !== 32'd17) begin bad++; $display("FAIL wrap_retired32 got=%0d want=17", retired_cnt); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
        bp_en = 1'b0; bp_addr = 32'h0; pc = 32'h3000; instr = ADDI;
        @(posedge clk);
        #1;
        test_reset();
        test_syscall();
        test_breakpoint();
        test_single_step();
        test_back_to_back();
        test_mid_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
